// File: rtl/mem_issue_queue.sv
// In-order load/store issue queue: holds dispatched memory ops, captures operands from
// writeback wakeups, and issues the head entry to memblock once its operands are ready.
module mem_issue_queue #(
   parameter int DEPTH   = 8,
   parameter int ROBID_W = 7,
   parameter int PREG_W  = 6,
   parameter int XLEN    = 64
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enq_valid,
   output logic                      enq_ready,
   input  logic [ROBID_W-1:0]        enq_robid,
   input  logic [PREG_W-1:0]         enq_prd,
   input  logic [PREG_W-1:0]         enq_prs1,
   input  logic [PREG_W-1:0]         enq_prs2,
   input  logic                      enq_src1_rdy,
   input  logic                      enq_src2_rdy,
   input  logic [XLEN-1:0]           enq_src1,
   input  logic [XLEN-1:0]           enq_src2,
   input  logic [XLEN-1:0]           enq_imm,
   input  logic                      enq_is_load,
   input  logic                      enq_is_store,
   input  logic                      enq_is_unsigned,
   input  logic [3:0]                enq_ls_size,
   input  logic [63:0]               enq_pc,
   input  logic [31:0]               enq_instr,
   input  logic [1:0]                wb_valid,
   input  logic [2*PREG_W-1:0]       wb_prd,
   input  logic [2*XLEN-1:0]         wb_data,
   output logic                      iss_valid,
   input  logic                      iss_ready,
   output logic [ROBID_W-1:0]        iss_robid,
   output logic [PREG_W-1:0]         iss_prd,
   output logic [XLEN-1:0]           iss_src1,
   output logic [XLEN-1:0]           iss_src2,
   output logic [XLEN-1:0]           iss_imm,
   output logic                      iss_is_load,
   output logic                      iss_is_store,
   output logic                      iss_is_unsigned,
   output logic [3:0]                iss_ls_size,
   output logic [63:0]               iss_pc,
   output logic [31:0]               iss_instr,
   input  logic                      flush_valid,
   input  logic [ROBID_W-1:0]        flush_robid,
   output logic [$clog2(DEPTH):0]    count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [CW-1:0]      head_q, tail_q, count_q, head_nxt, tail_nxt, survivors;
   logic [AW-1:0]      head_idx, tail_idx;
   logic [DEPTH-1:0]   valid_q, rdy1_q, rdy2_q, ld_q, st_q, uns_q, kill;
   logic [ROBID_W-1:0] robid_q [DEPTH];
   logic [PREG_W-1:0]  prd_q   [DEPTH];
   logic [PREG_W-1:0]  prs1_q  [DEPTH];
   logic [PREG_W-1:0]  prs2_q  [DEPTH];
   logic [XLEN-1:0]    src1_q  [DEPTH];
   logic [XLEN-1:0]    src2_q  [DEPTH];
   logic [XLEN-1:0]    imm_q   [DEPTH];
   logic [3:0]         size_q  [DEPTH];
   logic [63:0]        pc_q    [DEPTH];
   logic [31:0]        instr_q [DEPTH];
   logic [XLEN:0]      wk1 [DEPTH];
   logic [XLEN:0]      wk2 [DEPTH];
   logic [XLEN:0]      enq_wk1, enq_wk2;
   logic               full, enq_fire, head_killed, head_show, fire;

   function automatic logic younger(input logic [ROBID_W-1:0] a, input logic [ROBID_W-1:0] f);
      return (a[ROBID_W-1] ^ f[ROBID_W-1]) ^ (f[ROBID_W-2:0] < a[ROBID_W-2:0]);
   endfunction

   // Returns {rdy, value}; port 1 overrides port 0, preg 0 never matches.
   function automatic logic [XLEN:0] wake(input logic [PREG_W-1:0] prs, input logic rdy,
                                          input logic [XLEN-1:0] val, input logic [1:0] wbv,
                                          input logic [2*PREG_W-1:0] wbp, input logic [2*XLEN-1:0] wbd);
      logic [XLEN:0] r;
      r = {rdy, val};
      if (!rdy && prs != '0) begin
         if (wbv[0] && wbp[PREG_W-1:0] == prs)        r = {1'b1, wbd[XLEN-1:0]};
         if (wbv[1] && wbp[2*PREG_W-1:PREG_W] == prs) r = {1'b1, wbd[2*XLEN-1:XLEN]};
      end
      return r;
   endfunction

   always_comb begin
      head_idx  = head_q[AW-1:0];
      tail_idx  = tail_q[AW-1:0];
      full      = (head_idx == tail_idx) && (head_q[AW] != tail_q[AW]);
      enq_ready = ~full & ~flush_valid;
      enq_fire  = enq_valid & enq_ready;
      survivors = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         kill[i]   = valid_q[i] & flush_valid & younger(robid_q[i], flush_robid);
         survivors = survivors + CW'(valid_q[i] & ~kill[i]);
         wk1[i]    = wake(prs1_q[i], rdy1_q[i], src1_q[i], wb_valid, wb_prd, wb_data);
         wk2[i]    = wake(prs2_q[i], rdy2_q[i], src2_q[i], wb_valid, wb_prd, wb_data);
      end
      enq_wk1     = wake(enq_prs1, enq_src1_rdy, enq_src1, wb_valid, wb_prd, wb_data);
      enq_wk2     = wake(enq_prs2, enq_src2_rdy, enq_src2, wb_valid, wb_prd, wb_data);
      head_killed = kill[head_idx];
      head_show   = valid_q[head_idx];
      iss_valid   = head_show & rdy1_q[head_idx] & (rdy2_q[head_idx] | ld_q[head_idx]) & ~head_killed;
      fire        = iss_valid & iss_ready;
      head_nxt    = head_q + CW'(fire);
      // Killed entries sit contiguously at the tail, so the survivors count locates the new tail.
      tail_nxt    = flush_valid ? head_q + survivors : tail_q + CW'(enq_fire);

      iss_robid       = head_show ? robid_q[head_idx] : '0;
      iss_prd         = head_show ? prd_q[head_idx]   : '0;
      iss_src1        = head_show ? src1_q[head_idx]  : '0;
      iss_src2        = head_show ? src2_q[head_idx]  : '0;
      iss_imm         = head_show ? imm_q[head_idx]   : '0;
      iss_is_load     = head_show & ld_q[head_idx];
      iss_is_store    = head_show & st_q[head_idx];
      iss_is_unsigned = head_show & uns_q[head_idx];
      iss_ls_size     = head_show ? size_q[head_idx]  : '0;
      iss_pc          = head_show ? pc_q[head_idx]    : '0;
      iss_instr       = head_show ? instr_q[head_idx] : '0;
   end

   assign count = count_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         head_q  <= head_nxt;
         tail_q  <= tail_nxt;
         count_q <= tail_nxt - head_nxt;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
               {rdy1_q[i], src1_q[i]} <= wk1[i];
               {rdy2_q[i], src2_q[i]} <= wk2[i];
            end
            if (kill[i]) valid_q[i] <= 1'b0;
         end
         if (fire) valid_q[head_idx] <= 1'b0;
         if (enq_fire) begin
            valid_q[tail_idx]                  <= 1'b1;
            {rdy1_q[tail_idx], src1_q[tail_idx]} <= enq_wk1;
            {rdy2_q[tail_idx], src2_q[tail_idx]} <= enq_wk2;
            robid_q[tail_idx] <= enq_robid;
            prd_q[tail_idx]   <= enq_prd;
            prs1_q[tail_idx]  <= enq_prs1;
            prs2_q[tail_idx]  <= enq_prs2;
            imm_q[tail_idx]   <= enq_imm;
            ld_q[tail_idx]    <= enq_is_load;
            st_q[tail_idx]    <= enq_is_store;
            uns_q[tail_idx]   <= enq_is_unsigned;
            size_q[tail_idx]  <= enq_ls_size;
            pc_q[tail_idx]    <= enq_pc;
            instr_q[tail_idx] <= enq_instr;
         end
      end
   end
endmodule
